// File: rtl/dpram_pkg.sv
// dpram_pkg: shared FSM state type and byte-lane helpers for dual_syn_ram_param.
package dpram_pkg;
    typedef enum logic {S_INIT, S_RUN} dpram_state_t;
    localparam int LANE_W = 8;
    function automatic int lanes(input int width);
        return width / LANE_W;
    endfunction
endpackage

// File: rtl/dual_syn_ram_param_if.sv
// dual_syn_ram_param_if: write/read/clear bus of the dual-port RAM.
interface dual_syn_ram_param_if
    import dpram_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_BUS = $clog2(DEPTH)
);
    localparam int NB = lanes(WIDTH);
    logic                clr;
    logic                we;
    logic [NB-1:0]       be;
    logic [ADDR_BUS-1:0] wr_addr;
    logic [WIDTH-1:0]    din;
    logic                re;
    logic [ADDR_BUS-1:0] rd_addr;
    logic [WIDTH-1:0]    dout;
    logic                dout_valid;
    logic                busy;
    modport master (output clr, we, be, wr_addr, din, re, rd_addr, input dout, dout_valid, busy);
    modport slave  (input clr, we, be, wr_addr, din, re, rd_addr, output dout, dout_valid, busy);
endinterface

// File: rtl/dpram_init_ctrl.sv
// dpram_init_ctrl: clear sequencer sweeping every address once after reset or clr.
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_BUS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    output logic                busy,
    output logic                sweep_we,
    output logic [ADDR_BUS-1:0] sweep_addr
);
    localparam logic [ADDR_BUS-1:0] LAST = ADDR_BUS'(DEPTH - 1);
    dpram_state_t        state_q, state_d;
    logic [ADDR_BUS-1:0] sweep_addr_q, sweep_addr_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            sweep_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        if (state_q == S_INIT) begin
            state_d      = (sweep_addr_q == LAST) ? S_RUN : S_INIT;
            sweep_addr_d = (sweep_addr_q == LAST) ? '0 : sweep_addr_q + 1'b1;
        end else if (clr) begin
            state_d      = S_INIT;
            sweep_addr_d = '0;
        end
    end
    assign busy       = (state_q == S_INIT);
    assign sweep_we   = busy;
    assign sweep_addr = sweep_addr_q;
endmodule

// File: rtl/dual_syn_ram_param.sv
// dual_syn_ram_param: simple dual-port RAM with byte enables, clear sweep and read-valid.
// Define DPRAM_WR_BYPASS_EN for write-first same-address reads (read-first otherwise).
module dual_syn_ram_param
    import dpram_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 16,
    parameter int               ADDR_BUS = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_syn_ram_param_if.slave bus
);
    localparam int NB = lanes(WIDTH);
    localparam logic [ADDR_BUS:0] DEPTH_X = (ADDR_BUS + 1)'(DEPTH);
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                busy, sweep_we, wr_ok, rd_ok, rd_in, wen, dout_valid_q;
    logic [ADDR_BUS-1:0] sweep_addr, wa;
    logic [WIDTH-1:0]    wd, rd_d, dout_q;
    logic [NB-1:0]       wbe;
    dpram_init_ctrl #(.DEPTH(DEPTH), .ADDR_BUS(ADDR_BUS)) u_init (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.clr),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );
    // Out-of-range addresses only exist for non-power-of-2 DEPTH.
    assign wr_ok = bus.we && !busy && ({1'b0, bus.wr_addr} < DEPTH_X);
    assign rd_in = {1'b0, bus.rd_addr} < DEPTH_X;
    assign rd_ok = bus.re && !busy;
    assign wen   = busy ? sweep_we : wr_ok;
    assign wa    = busy ? sweep_addr : bus.wr_addr;
    assign wd    = busy ? INIT_VAL : bus.din;
    assign wbe   = busy ? '1 : bus.be;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (wen && wbe[i]) mem[wa][LANE_W*i +: LANE_W] <= wd[LANE_W*i +: LANE_W];
    end
    always_comb begin
        rd_d = rd_in ? mem[bus.rd_addr] : '0;
`ifdef DPRAM_WR_BYPASS_EN
        for (int i = 0; i < NB; i++)
            if (wr_ok && bus.wr_addr == bus.rd_addr && bus.be[i])
                rd_d[LANE_W*i +: LANE_W] = bus.din[LANE_W*i +: LANE_W];
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_ok;
            if (rd_ok) dout_q <= rd_d;
        end
    end
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_dual_syn_ram_param.sv
// tb_dual_syn_ram_param: random + directed check of two RAM configurations against a behavioural model.
module tb_dual_syn_ram_param;
    localparam logic [7:0]  INIT_A = 8'h00;
    localparam logic [15:0] INIT_B = 16'h5A3C;
`ifdef DPRAM_WR_BYPASS_EN
    localparam logic [7:0] SAME_EXP = 8'h5A;
`else
    localparam logic [7:0] SAME_EXP = 8'h11;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] mm [2][16];
    int          bl [2];
    logic        vv [2];
    logic [15:0] dd [2];

    always #5 clk = ~clk;

    dual_syn_ram_param_if #(.WIDTH(8), .DEPTH(16)) ia ();
    dual_syn_ram_param_if #(.WIDTH(16), .DEPTH(10)) ib ();

    dual_syn_ram_param #(.WIDTH(8), .DEPTH(16), .INIT_VAL(INIT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    dual_syn_ram_param #(.WIDTH(16), .DEPTH(10), .INIT_VAL(INIT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Busy lasts DEPTH edges; the array only becomes observable once it ends, so fill at the end.
    task automatic model(input int k, input int depth, input int nb, input logic [15:0] init,
                         input logic we, input logic [1:0] be, input int wa, input logic [15:0] din,
                         input logic re, input int ra, input logic clr);
        logic [15:0] rd;
        if (bl[k] > 0) begin
            bl[k]--;
            if (bl[k] == 0) for (int i = 0; i < depth; i++) mm[k][i] = init;
            vv[k] = 1'b0;
        end else begin
            vv[k] = re;
            if (re) begin
                rd = (ra < depth) ? mm[k][ra] : 16'h0;
`ifdef DPRAM_WR_BYPASS_EN
                if (we && wa == ra && ra < depth)
                    for (int i = 0; i < nb; i++) if (be[i]) rd[8*i +: 8] = din[8*i +: 8];
`endif
                dd[k] = rd;
            end
            if (we && wa < depth)
                for (int i = 0; i < nb; i++) if (be[i]) mm[k][wa][8*i +: 8] = din[8*i +: 8];
            if (clr) bl[k] = depth;
        end
    endtask

    task automatic chk_all();
        chk("a_busy",  16'(ia.busy),       16'(bl[0] > 0));
        chk("a_valid", 16'(ia.dout_valid), 16'(vv[0]));
        chk("a_dout",  16'(ia.dout),       dd[0]);
        chk("b_busy",  16'(ib.busy),       16'(bl[1] > 0));
        chk("b_valid", 16'(ib.dout_valid), 16'(vv[1]));
        chk("b_dout",  ib.dout,            dd[1]);
    endtask

    task automatic idle();
        ia.we = 0; ia.re = 0; ia.clr = 0;
        ib.we = 0; ib.re = 0; ib.clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model(0, 16, 1, 16'(INIT_A), ia.we, {1'b0, ia.be}, int'(ia.wr_addr), 16'(ia.din),
                  ia.re, int'(ia.rd_addr), ia.clr);
            model(1, 10, 2, INIT_B, ib.we, ib.be, int'(ib.wr_addr), ib.din,
                  ib.re, int'(ib.rd_addr), ib.clr);
        end
        #1;
        chk_all();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bl[0] = 16; bl[1] = 10;
        vv[0] = 1'b0; vv[1] = 1'b0;
        dd[0] = '0; dd[1] = '0;
        #1;
        chk_all();
    endtask

    task automatic wa(input logic [3:0] a, input logic [7:0] d);
        ia.we = 1; ia.be = 1'b1; ia.wr_addr = a; ia.din = d;
    endtask
    task automatic ra(input logic [3:0] a);
        ia.re = 1; ia.rd_addr = a;
    endtask
    task automatic wb(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        ib.we = 1; ib.be = be; ib.wr_addr = a; ib.din = d;
    endtask
    task automatic rb(input logic [3:0] a);
        ib.re = 1; ib.rd_addr = a;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) mm[k][i] = '0;
        ia.be = '0; ia.wr_addr = '0; ia.din = '0; ia.rd_addr = '0;
        ib.be = '0; ib.wr_addr = '0; ib.din = '0; ib.rd_addr = '0;
        idle();
        do_reset();
        tick(); tick();
        rst_n = 1'b1;
        repeat (16) tick();
        for (int i = 0; i < 16; i++) begin
            ra(4'(i));
            if (i < 10) rb(4'(i));
            tick();
        end
        tick();
        wa(4'hA, 8'hA5); tick();
        ra(4'hA); tick();
        chk("a_rd_a5", 16'(ia.dout), 16'h00A5);
        tick(); tick();
        chk("a_hold_a5", 16'(ia.dout), 16'h00A5);
        wb(4'd3, 16'h1234, 2'b11); tick();
        wb(4'd3, 16'hABCD, 2'b10); tick();
        rb(4'd3); tick();
        chk("b_lane_merge", ib.dout, 16'hAB34);
        wa(4'd2, 8'h11); tick();
        wa(4'd2, 8'h5A); ra(4'd2); tick();
        chk("a_same_cycle", 16'(ia.dout), 16'(SAME_EXP));
        ra(4'd2); tick();
        chk("a_after_same", 16'(ia.dout), 16'h005A);
        for (int i = 0; i < 16; i++) begin wa(4'(i), 8'hFF); tick(); end
        ia.clr = 1; tick();
        for (int i = 0; i < 16; i++) begin wa(4'(i), 8'h77); ra(4'(i)); ia.clr = 1; tick(); end
        for (int i = 0; i < 16; i++) begin ra(4'(i)); tick(); end
        wa(4'd3, 8'hC3); tick();
        ra(4'd3); rb(4'd3); tick();
        ia.clr = 1; tick();
        repeat (7) tick();
        #2;
        do_reset();
        chk("a_mid_rst_dout", 16'(ia.dout), 16'h0000);
        chk("b_mid_rst_dout", ib.dout, 16'h0000);
        tick();
        rst_n = 1'b1;
        repeat (16) tick();
        rb(4'd12); tick();
        chk("b_oor_rd", ib.dout, 16'h0000);
        wb(4'd12, 16'hFFFF, 2'b11); tick();
        for (int i = 0; i < 10; i++) begin rb(4'(i)); tick(); end
        repeat (400) begin
            if ($urandom_range(0, 1) == 1) begin
                ia.we = 1; ia.be = 1'($urandom_range(0, 3) != 0);
                ia.wr_addr = 4'($urandom_range(0, 15)); ia.din = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin ia.re = 1; ia.rd_addr = 4'($urandom_range(0, 15)); end
            if ($urandom_range(0, 1) == 1) begin
                ib.we = 1; ib.be = 2'($urandom_range(0, 3));
                ib.wr_addr = 4'($urandom_range(0, 15)); ib.din = 16'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin ib.re = 1; ib.rd_addr = 4'($urandom_range(0, 15)); end
            ia.clr = ($urandom_range(0, 63) == 0);
            ib.clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        repeat (16) tick();
        for (int i = 0; i < 16; i++) begin ra(4'(i)); rb(4'(i)); tick(); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dual_syn_ram_param.md
Name: dual_syn_ram_param

Overview:
- Parametrised simple dual-port synchronous RAM: one write port and one read port, both on a single clock.
- Adds per-byte write enables, a hardware clear sequencer that sweeps the array to INIT_VAL after reset or on request, and a valid flag on read data.
- General-purpose storage for buffers and register banks in the datapath; replaces the fixed 16x8 dual-port RAM.

Parameters:
- WIDTH, 8, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of 2.
- ADDR_BUS, $clog2(DEPTH), address width.
- NB, WIDTH/8, number of byte lanes (derived; not overridden).
- INIT_VAL, 0, word value written to every location by the clear sweep.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear request; honoured only when busy=0.
- we  in  1  write enable.
- be  in  NB  byte-lane enables; lane i covers din[8i+7:8i].
- wr_addr  in  ADDR_BUS  write address.
- din  in  WIDTH  write data.
- re  in  1  read enable.
- rd_addr  in  ADDR_BUS  read address.
- dout  out  WIDTH  read data, registered.
- dout_valid  out  1  dout updated this cycle.
- busy  out  1  clear sweep in progress; ports ignored.

Behaviour:
- Reset: rst_n low forces dout=0, dout_valid=0, busy=1, FSM=S_INIT, sweep_addr=0. Array contents are not reset directly.
- FSM states: S_INIT and S_RUN.
  - S_INIT: each clock writes INIT_VAL to sweep_addr, then increments sweep_addr.
  - When sweep_addr==DEPTH-1, the FSM moves to S_RUN on that edge.
  - busy stays 1 for exactly DEPTH cycles after rst_n rises.
- S_RUN with clr=1: FSM returns to S_INIT with sweep_addr=0. busy=1 from the next cycle.
  - A we or re in the same cycle as clr is still performed.
- While busy=1: we, re and clr are ignored, and dout_valid=0.
- Write: on the edge where we=1 and busy=0, mem[wr_addr] lane i <= din lane i for every be[i]=1. Other lanes are unchanged. be=0 means no change.
- Read latency is 1:
  - re=1 at edge N gives dout=mem[rd_addr] and dout_valid=1 after edge N.
  - dout_valid is a one-cycle pulse per accepted read.
  - Back-to-back reads give one word per cycle.
- dout holds its last value when re=0.
- Address out of range (addr >= DEPTH, only possible for non-power-of-2 DEPTH):
  - Write is dropped.
  - Read returns dout=0 with dout_valid=1.
- Same-address read and write in one cycle: read-first by default (dout = old word). See Optional Feature for write-first.
- Reset asserted mid-sweep or mid-access: behaves as a fresh reset. The sweep restarts from address 0, and any in-flight read result is discarded.
- Widths: all address comparisons use ADDR_BUS bits, and sweep_addr is ADDR_BUS bits. No wrap-around past DEPTH-1.

Optional Feature:
- Macro: DPRAM_WR_BYPASS_EN.
- Defined: same-address read and write in one cycle returns write-first data. dout lane i = din lane i when be[i]=1, otherwise the old mem lane.
- Undefined: read-first, returning the old word. Block RAM inference is preserved.
- No effect on latency or dout_valid.

Decomposition:
- Package dpram_pkg:
  - typedef enum {S_INIT, S_RUN} dpram_state_t.
  - Constant helper for byte-lane merge width.
- Sub-module dpram_init_ctrl: FSM plus sweep counter.
  - Inputs: clk, rst_n, clr.
  - Outputs: busy, sweep_we, sweep_addr.
- The top level muxes sweep_we/sweep_addr/INIT_VAL onto the write port while busy=1.

Test Plan:
- Reset release, DEPTH=16: busy=1 for exactly 16 cycles, then 0. Reading all 16 addresses returns 0, with dout_valid pulsing once per read.
- Write 8'hA5 to addr 4'hA with be=1, then read 4'hA next cycle: dout=8'hA5 and dout_valid=1 one cycle after re. dout holds 8'hA5 with re=0.
- WIDTH=16: write 16'h1234 to addr 3, then write 16'hABCD with be=2'b10: a read of addr 3 returns 16'hAB34.
- Same-cycle write 8'h5A and read of addr 2 (old value 8'h11):
  - macro undefined: dout=8'h11.
  - DPRAM_WR_BYPASS_EN defined: dout=8'h5A.
  - A later read returns 8'h5A in both builds.
- clr pulse after filling memory with 8'hFF:
  - busy=1 for 16 cycles.
  - re/we asserted during busy are ignored, with dout_valid=0.
  - After busy falls, all reads return INIT_VAL.
- rst_n pulsed low at sweep cycle 7: outputs go to reset values immediately. After release, busy stays 1 for a full 16 cycles. DEPTH=10 read of addr 12 gives dout=0, and a write to addr 12 is dropped.
